// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage: RV32I opcodes,
// ALU operation codes, the issue packet layout and the occupancy states.
package alu_pkg;

    localparam int DATA_W = 32;

    // RV32I major opcodes handled by the issue stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values that distinguish base, alternate (SUB/SRA) forms
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_OR    = 5'd2;
    localparam logic [4:0] ALU_XOR   = 5'd3;
    localparam logic [4:0] ALU_AND   = 5'd4;
    localparam logic [4:0] ALU_SLL   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_PASSB = 5'd8;

    // One decoded instruction, ready for the ALU
    typedef struct packed {
        logic [DATA_W-1:0] inA;
        logic [DATA_W-1:0] inB;
        logic [4:0]        alu_op;
        logic [4:0]        rd;
        logic              we;
        logic              illegal;
    } issue_pkt_t;

    // Number of packets held by the stage
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC. Produces the
// ALU operands, operation code and write-back control for one instruction.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output issue_pkt_t  pkt_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic        legal;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd     = instr_i[11:7];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_u  = {instr_i[31:12], 12'b0};

    // Decode opcode/funct fields into operands and ALU operation
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        pkt_o        = '0;
        pkt_o.rd     = rd;
        legal        = 1'b1;

        case (opcode)
            OPC_OP: begin
                pkt_o.inA = rs1_data_i;
                pkt_o.inB = rs2_data_i;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE)     pkt_o.alu_op = ALU_ADD;
                        else if (funct7 == F7_ALT) pkt_o.alu_op = ALU_SUB;
                        else                       legal = 1'b0;
                    end
                    3'b001: begin
                        pkt_o.alu_op = ALU_SLL;
                        pkt_o.inB    = {27'b0, rs2_data_i[4:0]};
                        legal        = (funct7 == F7_BASE);
                    end
                    3'b100: begin
                        pkt_o.alu_op = ALU_XOR;
                        legal        = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        pkt_o.inB = {27'b0, rs2_data_i[4:0]};
                        if (funct7 == F7_BASE)     pkt_o.alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) pkt_o.alu_op = ALU_SRA;
                        else                       legal = 1'b0;
                    end
                    3'b110: begin
                        pkt_o.alu_op = ALU_OR;
                        legal        = (funct7 == F7_BASE);
                    end
                    3'b111: begin
                        pkt_o.alu_op = ALU_AND;
                        legal        = (funct7 == F7_BASE);
                    end
                    default: legal = 1'b0;  // SLT, SLTU
                endcase
            end

            OPC_OP_IMM: begin
                pkt_o.inA = rs1_data_i;
                pkt_o.inB = imm_i;
                case (funct3)
                    3'b000: pkt_o.alu_op = ALU_ADD;
                    3'b100: pkt_o.alu_op = ALU_XOR;
                    3'b110: pkt_o.alu_op = ALU_OR;
                    3'b111: pkt_o.alu_op = ALU_AND;
                    3'b001: begin
                        pkt_o.alu_op = ALU_SLL;
                        pkt_o.inB    = {27'b0, instr_i[24:20]};
                        legal        = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        pkt_o.inB = {27'b0, instr_i[24:20]};
                        if (funct7 == F7_BASE)     pkt_o.alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) pkt_o.alu_op = ALU_SRA;
                        else                       legal = 1'b0;
                    end
                    default: legal = 1'b0;  // SLTI, SLTIU
                endcase
            end

            OPC_LUI: begin
                pkt_o.alu_op = ALU_PASSB;
                pkt_o.inB    = imm_u;
            end

            OPC_AUIPC: begin
                pkt_o.alu_op = ALU_ADD;
                pkt_o.inA    = pc_i;
                pkt_o.inB    = imm_u;
            end

            default: legal = 1'b0;
        endcase

        // Illegal instructions carry only rd and the illegal flag
        if (!legal) begin
            pkt_o         = '0;
            pkt_o.rd      = rd;
            pkt_o.illegal = 1'b1;
        end else begin
            pkt_o.we = (rd != 5'd0);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction per accepted input and holds up
// to two issue packets (output register plus skid entry) so that in_ready
// can come straight from a flop. Only XLEN = 32 is supported.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inA,
    output logic [XLEN-1:0] out_inB,
    output logic [4:0]      out_alu_op,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    occ_state_t state_q, state_d;
    issue_pkt_t head_q, head_d;
    issue_pkt_t skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    issue_pkt_t dec_pkt;
    logic       accept;
    logic       drain;

    alu_issue_decode u_decode (
        .instr_i    (in_instr),
        .pc_i       (in_pc),
        .rs1_data_i (in_rs1_data),
        .rs2_data_i (in_rs2_data),
        .pkt_o      (dec_pkt)
    );

    assign out_valid = (state_q != OCC_EMPTY);
    assign accept    = in_valid && in_ready_q;
    assign drain     = out_valid && out_ready;

    // Occupancy next-state and packet movement between skid and head
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_d  = dec_pkt;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && drain) begin
                        head_d = dec_pkt;
                    end else if (accept) begin
                        skid_d  = dec_pkt;
                        state_d = OCC_TWO;
                    end else if (drain) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (drain) begin
                        head_d  = skid_q;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end

        in_ready_d = (state_d != OCC_TWO);
    end

    // State, ready and packet registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: both packet registers are reset as well, because the data
        // outputs are required to read zero after reset, not just be ignored.
        if (!rst_n) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_inA     = head_q.inA;
    assign out_inB     = head_q.inB;
    assign out_alu_op  = head_q.alu_op;
    assign out_rd      = head_q.rd;
    assign out_we      = head_q.we;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: decode vectors, backpressure,
// flush and mid-stream reset, with hand-computed expected values.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inA;
    logic [31:0] out_inB;
    logic [4:0]  out_alu_op;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    int tests_run;
    int tests_failed;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inA     (out_inA),
        .out_inB     (out_inB),
        .out_alu_op  (out_alu_op),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_illegal (out_illegal)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2);
        in_valid    = v;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
    endtask

    // Offer one instruction for one edge, then withdraw it
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        drive(1'b1, instr, pc, rs1, rs2);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] op,
                             input logic [4:0] rd, input logic we,
                             input logic ill);
        check({tag, ".valid"},   {31'b0, out_valid},   32'd1);
        check({tag, ".inA"},     out_inA,              a);
        check({tag, ".inB"},     out_inB,              b);
        check({tag, ".op"},      {27'b0, out_alu_op},  {27'b0, op});
        check({tag, ".rd"},      {27'b0, out_rd},      {27'b0, rd});
        check({tag, ".we"},      {31'b0, out_we},      {31'b0, we});
        check({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset state
        tick();
        tick();
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.in_ready",  {31'b0, in_ready},  32'd1);
        check("rst.inA",       out_inA,            32'd0);
        check("rst.inB",       out_inB,            32'd0);
        check("rst.op",        {27'b0, out_alu_op}, 32'd0);
        check("rst.rd",        {27'b0, out_rd},    32'd0);
        check("rst.we",        {31'b0, out_we},    32'd0);
        rst_n = 1'b1;
        tick();

        // ADDI x1,x0,5
        issue(32'h00500093, 32'h0, 32'h0, 32'h0);
        check_pkt("addi", 32'h0, 32'h5, 5'd0, 5'd1, 1'b1, 1'b0);
        tick();
        check("addi.drained", {31'b0, out_valid}, 32'd0);

        // SUB x3,x1,x2
        issue(32'h402081B3, 32'h0, 32'd10, 32'd3);
        check_pkt("sub", 32'd10, 32'd3, 5'd1, 5'd3, 1'b1, 1'b0);
        tick();

        // SRAI x5,x6,3
        issue(32'h40335293, 32'h0, 32'h000000F0, 32'h0);
        check_pkt("srai", 32'h000000F0, 32'd3, 5'd7, 5'd5, 1'b1, 1'b0);
        tick();

        // SLL x9,x1,x2 with rs2=0x25: only the low 5 bits feed inB
        issue(32'h002094B3, 32'h0, 32'h11, 32'h25);
        check_pkt("sll", 32'h11, 32'd5, 5'd5, 5'd9, 1'b1, 1'b0);
        tick();

        // LUI x7,0x12345: inA forced to zero despite rs1 data
        issue(32'h123453B7, 32'h0, 32'hDEADBEEF, 32'h0);
        check_pkt("lui", 32'h0, 32'h12345000, 5'd8, 5'd7, 1'b1, 1'b0);
        tick();

        // AUIPC x8,1 at pc 0x100
        issue(32'h00001417, 32'h100, 32'h0, 32'h0);
        check_pkt("auipc", 32'h100, 32'h1000, 5'd0, 5'd8, 1'b1, 1'b0);
        tick();

        // SLT x4,x1,x2 is illegal: operands zero, we=0, rd kept
        issue(32'h0020A233, 32'h0, 32'h55, 32'h66);
        check_pkt("slt", 32'h0, 32'h0, 5'd0, 5'd4, 1'b0, 1'b1);
        tick();

        // ADDI x0,x0,-1: sign-extended immediate, no write to x0
        issue(32'hFFF00013, 32'h0, 32'h0, 32'h0);
        check_pkt("addi_x0", 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();

        // Backpressure: three offers with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h0, 32'h0, 32'h0);  // ADDI x1,x0,1
        tick();
        check("bp.ready_after_1", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'h00200113, 32'h0, 32'h0, 32'h0);  // ADDI x2,x0,2
        tick();
        check("bp.ready_after_2", {31'b0, in_ready}, 32'd0);
        check("bp.head_inB",      out_inB,           32'd1);
        drive(1'b1, 32'h00300193, 32'h0, 32'h0, 32'h0);  // ADDI x3,x0,3
        tick();
        check("bp.still_full",    {31'b0, in_ready}, 32'd0);
        check("bp.stable_inB",    out_inB,           32'd1);
        check("bp.stable_rd",     {27'b0, out_rd},   32'd1);
        out_ready = 1'b1;
        tick();
        check("bp.drain1_inB",    out_inB,           32'd2);
        check("bp.drain1_ready",  {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp.third_inB",     out_inB,           32'd3);
        check("bp.third_rd",      {27'b0, out_rd},   32'd3);
        check("bp.third_valid",   {31'b0, out_valid}, 32'd1);
        tick();
        check("bp.empty",         {31'b0, out_valid}, 32'd0);

        // Flush while full with a packet on the input
        out_ready = 1'b0;
        drive(1'b1, 32'h01100093, 32'h0, 32'h0, 32'h0);  // ADDI x1,x0,17
        tick();
        drive(1'b1, 32'h01200113, 32'h0, 32'h0, 32'h0);  // ADDI x2,x0,18
        tick();
        check("fl.full", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h01300193, 32'h0, 32'h0, 32'h0);  // ADDI x3,x0,19
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl.out_valid", {31'b0, out_valid}, 32'd0);
        check("fl.in_ready",  {31'b0, in_ready},  32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl.nothing_left", {31'b0, out_valid}, 32'd0);
        issue(32'h00400213, 32'h0, 32'h0, 32'h0);         // ADDI x4,x0,4
        check_pkt("fl.after", 32'h0, 32'd4, 5'd0, 5'd4, 1'b1, 1'b0);
        tick();

        // Reset mid-stream while full
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 32'h00600113, 32'h0, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        check("mr.full", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        check("mr.out_valid", {31'b0, out_valid}, 32'd0);
        check("mr.in_ready",  {31'b0, in_ready},  32'd1);
        check("mr.inA",       out_inA,            32'd0);
        check("mr.inB",       out_inB,            32'd0);
        check("mr.rd",        {27'b0, out_rd},    32'd0);
        check("mr.we",        {31'b0, out_we},    32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
